// File: rtl/capture_pkg.sv
// -----------------------------------------------------------------------------
// capture_pkg
// Shared definitions for the capture window controller slice.
//   - capture_state_t : controller state encoding
//   - DEFAULT_DATA_W  : default sample width in bits
//   - DEFAULT_ADDR_W  : default buffer address width
//   - depthOf()       : buffer depth in words for a given address width
// -----------------------------------------------------------------------------
package capture_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_ADDR_W = 10;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRETRIG  = 3'd1,
      POSTTRIG = 3'd2,
      DONE     = 3'd3,
      READOUT  = 3'd4,
      DRAINED  = 3'd5
   } capture_state_t;

   function automatic int depthOf(input int addrW);
      return 1 << addrW;
   endfunction

endpackage

// File: rtl/capture_sample_ram.sv
// -----------------------------------------------------------------------------
// capture_sample_ram
// Simple dual-port sample buffer: one write port and one registered read
// port with a single cycle of read latency, written so that synthesis maps
// it onto block RAM. Contents are never cleared.
// Ports:
//   Clock         system clock, rising edge
//   WrEn          write strobe
//   WrAddr        write address
//   WrData        write data
//   RdEn          read strobe; RdData updates on the following edge
//   RdAddr        read address
//   RdData        registered read data
// -----------------------------------------------------------------------------
module capture_sample_ram
   import capture_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              Clock,
   input  logic              WrEn,
   input  logic [ADDR_W-1:0] WrAddr,
   input  logic [DATA_W-1:0] WrData,
   input  logic              RdEn,
   input  logic [ADDR_W-1:0] RdAddr,
   output logic [DATA_W-1:0] RdData
);

   logic [DATA_W-1:0] mem [depthOf(ADDR_W)];

   // Write port: one sample per enabled cycle.
   always_ff @(posedge Clock) begin
      if (WrEn) begin
         mem[WrAddr] <= WrData;
      end
   end

   // Read port: registered output, holds its value when not enabled so the
   // readout pipeline can treat it as a one-deep stage.
   always_ff @(posedge Clock) begin
      if (RdEn) begin
         RdData <= mem[RdAddr];
      end
   end

endmodule

// File: rtl/capture_window_ctrl.sv
// -----------------------------------------------------------------------------
// capture_window_ctrl
// Records ADC samples into a circular buffer while armed so that pre-trigger
// history is kept; once EnableRecording rises it records a programmed number
// of post-trigger samples, freezes, and streams the captured window out
// oldest-first over a valid/ready handshake.
//
// Optional build macro CAPTURE_TIMESTAMP_EN adds TriggerTime, the number of
// clock cycles from PRETRIG entry to the trigger cycle (saturating).
//
// Ports:
//   Clock            system clock, rising edge
//   Reset            synchronous, active-high
//   Armed            level, enables pre-trigger recording
//   EnableRecording  level from the trigger latch, sticky once set
//   SampleValid      qualifies SampleData
//   SampleData       ADC sample
//   PostTrigCount    post-trigger samples to record, taken on the trigger cycle
//   ReadReady        consumer ready
//   ReadValid        ReadData holds a valid word
//   ReadData         readout word, oldest first
//   RecordDone       capture frozen, readout available or in progress
//   TriggerAddr      buffer address of the first post-trigger sample
//   TriggerTime      (CAPTURE_TIMESTAMP_EN only) cycles from arm to trigger
//   SampleCount      number of words in the captured window
// -----------------------------------------------------------------------------
module capture_window_ctrl
   import capture_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Armed,
   input  logic              EnableRecording,
   input  logic              SampleValid,
   input  logic [DATA_W-1:0] SampleData,
   input  logic [ADDR_W:0]   PostTrigCount,
   input  logic              ReadReady,
   output logic              ReadValid,
   output logic [DATA_W-1:0] ReadData,
   output logic              RecordDone,
   output logic [ADDR_W-1:0] TriggerAddr,
`ifdef CAPTURE_TIMESTAMP_EN
   output logic [31:0]       TriggerTime,
`endif
   output logic [ADDR_W:0]   SampleCount
);

   localparam int DEPTH = depthOf(ADDR_W);
   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

   capture_state_t state;
   capture_state_t nextState;

   logic [ADDR_W-1:0] wrPtr;
   logic [ADDR_W:0]   preFill;
   logic [ADDR_W:0]   postCnt;
   logic [ADDR_W:0]   pt;

   logic              wrEn;
   logic              trigger;
   logic              preInc;
   logic              preClr;
   logic              postInc;
   logic              doneEntry;

   logic [ADDR_W:0]   ptSat;
   logic [ADDR_W:0]   windowPt;
   logic [ADDR_W+1:0] windowSum;
   logic [ADDR_W:0]   windowSize;

   logic [ADDR_W-1:0] rdPtr;
   logic [ADDR_W:0]   rdIssued;
   logic [ADDR_W:0]   txCnt;
   logic              ramPending;
   logic [DATA_W-1:0] ramQ;
   logic              skidValid;
   logic [DATA_W-1:0] skidData;
   logic              pop;
   logic              issue;
   logic [1:0]        occAfterPop;

   // Post-trigger length is clamped to the buffer depth. The window size uses
   // the live clamped value on the trigger cycle itself (when pt is not yet
   // loaded) and the latched value afterwards, so it is correct whichever
   // cycle enters DONE.
   always_comb begin
      ptSat      = (PostTrigCount > DEPTH_CNT) ? DEPTH_CNT : PostTrigCount;
      windowPt   = (state == PRETRIG) ? ptSat : pt;
      windowSum  = {1'b0, preFill} + {1'b0, windowPt};
      windowSize = (windowSum > {1'b0, DEPTH_CNT}) ? DEPTH_CNT : windowSum[ADDR_W:0];
   end

   // State register.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and capture strobes. A trigger-cycle sample counts as the
   // first post-trigger sample, never as pre-trigger history, and a zero
   // post-trigger length freezes immediately without writing it.
   always_comb begin
      nextState = state;
      wrEn      = 1'b0;
      trigger   = 1'b0;
      preInc    = 1'b0;
      preClr    = 1'b0;
      postInc   = 1'b0;
      unique case (state)
         IDLE: begin
            if (Armed) begin
               nextState = PRETRIG;
            end
         end
         PRETRIG: begin
            if (EnableRecording) begin
               trigger = 1'b1;
               if (ptSat == '0) begin
                  nextState = DONE;
               end else begin
                  if (SampleValid) begin
                     wrEn    = 1'b1;
                     postInc = 1'b1;
                  end
                  if (SampleValid && (ptSat == (ADDR_W+1)'(1))) begin
                     nextState = DONE;
                  end else begin
                     nextState = POSTTRIG;
                  end
               end
            end else if (!Armed) begin
               nextState = IDLE;
               preClr    = 1'b1;
            end else if (SampleValid) begin
               wrEn   = 1'b1;
               preInc = 1'b1;
            end
         end
         POSTTRIG: begin
            if (SampleValid) begin
               wrEn    = 1'b1;
               postInc = 1'b1;
               if ((postCnt + (ADDR_W+1)'(1)) == pt) begin
                  nextState = DONE;
               end
            end
         end
         DONE: begin
            nextState = READOUT;
         end
         READOUT: begin
            if ((SampleCount == '0) ||
                (pop && ((txCnt + (ADDR_W+1)'(1)) == SampleCount))) begin
               nextState = DRAINED;
            end
         end
         DRAINED: begin
            nextState = DRAINED;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
      doneEntry = (nextState == DONE) && (state != DONE);
   end

   // Capture bookkeeping: write pointer, fill counters, trigger address and
   // the frozen window size. Leaving PRETRIG without a trigger keeps the
   // write pointer but forgets the history count.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         wrPtr       <= '0;
         preFill     <= '0;
         postCnt     <= '0;
         pt          <= '0;
         TriggerAddr <= '0;
         SampleCount <= '0;
         RecordDone  <= 1'b0;
      end else begin
         if (wrEn) begin
            wrPtr <= wrPtr + ADDR_W'(1);
         end
         if (preClr) begin
            preFill <= '0;
         end else if (preInc && (preFill != DEPTH_CNT)) begin
            preFill <= preFill + (ADDR_W+1)'(1);
         end
         if (trigger) begin
            TriggerAddr <= wrPtr;
            pt          <= ptSat;
            postCnt     <= postInc ? (ADDR_W+1)'(1) : '0;
         end else if (postInc) begin
            postCnt <= postCnt + (ADDR_W+1)'(1);
         end
         if (doneEntry) begin
            SampleCount <= windowSize;
            RecordDone  <= 1'b1;
         end
      end
   end

   capture_sample_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) sampleRam (
      .Clock  (Clock),
      .WrEn   (wrEn),
      .WrAddr (wrPtr),
      .WrData (SampleData),
      .RdEn   (issue),
      .RdAddr (rdPtr),
      .RdData (ramQ)
   );

   // Read issue control. The output register plus a one-word skid register
   // give two slots; a read is issued only if, after this cycle's transfer,
   // at most one slot is committed, so the word returning next cycle always
   // has somewhere to land. This sustains one word per cycle when ReadReady
   // stays high.
   always_comb begin
      pop         = ReadValid && ReadReady;
      occAfterPop = 2'(ReadValid) + 2'(skidValid) + 2'(ramPending) - 2'(pop);
      issue       = (state == READOUT) && (rdIssued != SampleCount) &&
                    (occAfterPop <= 2'd1);
   end

   // Readout pointers. The oldest word sits SampleCount entries behind the
   // final write pointer; a full window therefore starts at the write
   // pointer itself.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         rdPtr      <= '0;
         rdIssued   <= '0;
         txCnt      <= '0;
         ramPending <= 1'b0;
      end else begin
         ramPending <= issue;
         if (state == DONE) begin
            rdPtr    <= wrPtr - SampleCount[ADDR_W-1:0];
            rdIssued <= '0;
            txCnt    <= '0;
         end else begin
            if (issue) begin
               rdPtr    <= rdPtr + ADDR_W'(1);
               rdIssued <= rdIssued + (ADDR_W+1)'(1);
            end
            if (pop) begin
               txCnt <= txCnt + (ADDR_W+1)'(1);
            end
         end
      end
   end

   // Output and skid registers. The output refills from the skid word first
   // (it is older) and then from the RAM; while stalled the RAM word parks in
   // the skid register and the output stays untouched.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         ReadValid <= 1'b0;
         ReadData  <= '0;
         skidValid <= 1'b0;
         skidData  <= '0;
      end else if (state == READOUT) begin
         if (!ReadValid || pop) begin
            if (skidValid) begin
               ReadValid <= 1'b1;
               ReadData  <= skidData;
               skidValid <= ramPending;
               if (ramPending) begin
                  skidData <= ramQ;
               end
            end else if (ramPending) begin
               ReadValid <= 1'b1;
               ReadData  <= ramQ;
            end else begin
               ReadValid <= 1'b0;
            end
         end else if (ramPending) begin
            skidValid <= 1'b1;
            skidData  <= ramQ;
         end
      end else begin
         ReadValid <= 1'b0;
         skidValid <= 1'b0;
      end
   end

`ifdef CAPTURE_TIMESTAMP_EN
   logic [31:0] tsCount;

   // Cycle counter restarted on every entry into PRETRIG and captured on the
   // trigger cycle, so a trigger on the first armed cycle reports zero.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         tsCount     <= '0;
         TriggerTime <= '0;
      end else begin
         if ((state == IDLE) && (nextState == PRETRIG)) begin
            tsCount <= '0;
         end else if ((state == PRETRIG) && (tsCount != 32'hFFFF_FFFF)) begin
            tsCount <= tsCount + 32'd1;
         end
         if (trigger) begin
            TriggerTime <= tsCount;
         end
      end
   end
`endif

endmodule

// File: tb/tb_capture_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_capture_window_ctrl
// Drives two controller instances (default 10-bit buffer and a 16-word
// buffer for wrap checks); the idle one is held in reset. Expected readout
// words are queued as samples are sent, and per-instance monitors compare
// every transferred word and check hold-while-stalled.
// -----------------------------------------------------------------------------
module tb_capture_window_ctrl;

   logic        Clock = 1'b0;
   logic        resetA = 1'b1;
   logic        resetB = 1'b1;
   logic        armed = 1'b0;
   logic        enableRecording = 1'b0;
   logic        sampleValid = 1'b0;
   logic [7:0]  sampleData = '0;
   logic        readReady = 1'b0;
   logic [10:0] postTrigA = '0;
   logic [4:0]  postTrigB = '0;

   logic        readValidA, readValidB;
   logic [7:0]  readDataA, readDataB;
   logic        recordDoneA, recordDoneB;
   logic [9:0]  triggerAddrA;
   logic [3:0]  triggerAddrB;
   logic [10:0] sampleCountA;
   logic [4:0]  sampleCountB;
`ifdef CAPTURE_TIMESTAMP_EN
   logic [31:0] trigTimeA, trigTimeB;
`endif

   int checkCount = 0;
   int failCount  = 0;

   logic [7:0] expA[$];
   logic [7:0] expB[$];
   bit         stallA = 0;
   bit         stallB = 0;
   logic [7:0] heldA, heldB;

   always #5 Clock = ~Clock;

   capture_window_ctrl #(.DATA_W(8), .ADDR_W(10)) dutA (
      .Clock           (Clock),
      .Reset           (resetA),
      .Armed           (armed),
      .EnableRecording (enableRecording),
      .SampleValid     (sampleValid),
      .SampleData      (sampleData),
      .PostTrigCount   (postTrigA),
      .ReadReady       (readReady),
      .ReadValid       (readValidA),
      .ReadData        (readDataA),
      .RecordDone      (recordDoneA),
      .TriggerAddr     (triggerAddrA),
`ifdef CAPTURE_TIMESTAMP_EN
      .TriggerTime     (trigTimeA),
`endif
      .SampleCount     (sampleCountA)
   );

   capture_window_ctrl #(.DATA_W(8), .ADDR_W(4)) dutB (
      .Clock           (Clock),
      .Reset           (resetB),
      .Armed           (armed),
      .EnableRecording (enableRecording),
      .SampleValid     (sampleValid),
      .SampleData      (sampleData),
      .PostTrigCount   (postTrigB),
      .ReadReady       (readReady),
      .ReadValid       (readValidB),
      .ReadData        (readDataB),
      .RecordDone      (recordDoneB),
      .TriggerAddr     (triggerAddrB),
`ifdef CAPTURE_TIMESTAMP_EN
      .TriggerTime     (trigTimeB),
`endif
      .SampleCount     (sampleCountB)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Drives one sample cycle; optionally queues it as an expected readout word.
   task automatic applyStimulus(input logic sv, input logic [7:0] data,
                                input bit push, input int sel);
      sampleValid = sv;
      sampleData  = data;
      if (push) begin
         if (sel == 0) expA.push_back(data);
         else          expB.push_back(data);
      end
      tick();
      sampleValid = 1'b0;
   endtask

   task automatic doReset(input int sel);
      if (sel == 0) resetA = 1'b1;
      else          resetB = 1'b1;
      armed = 1'b0;
      enableRecording = 1'b0;
      sampleValid = 1'b0;
      readReady = 1'b0;
      postTrigA = '0;
      postTrigB = '0;
      tick();
      tick();
      if (sel == 0) begin resetA = 1'b0; expA.delete(); end
      else          begin resetB = 1'b0; expB.delete(); end
   endtask

   // Waits, bounded, for every queued word to be delivered.
   task automatic waitDrain(input int sel, input int bound, input bit randomReady);
      int sz;
      for (int n = 0; n < bound; n++) begin
         sz = (sel == 0) ? expA.size() : expB.size();
         if (sz == 0) break;
         if (randomReady) readReady = 1'($urandom_range(0, 1));
         tick();
      end
      sz = (sel == 0) ? expA.size() : expB.size();
      readReady = 1'b1;
      checkOutput(sel == 0 ? "drainA" : "drainB", sz, 0);
   endtask

   // Monitor for instance A: compares each transferred word and checks that
   // a stalled word stays valid and unchanged.
   always @(negedge Clock) begin
      logic [7:0] e;
      if (resetA) begin
         stallA = 0;
      end else begin
         if (stallA) begin
            checkOutput("holdValidA", readValidA, 1);
            if (readValidA) checkOutput("holdDataA", readDataA, heldA);
         end
         if (readValidA && readReady) begin
            if (expA.size() == 0) begin
               checkOutput("unexpectedWordA", readDataA, 32'hFFFF_FFFF);
            end else begin
               e = expA.pop_front();
               checkOutput("readDataA", readDataA, e);
            end
            stallA = 0;
         end else if (readValidA) begin
            stallA = 1;
            heldA  = readDataA;
         end else begin
            stallA = 0;
         end
      end
   end

   // Monitor for instance B, same checks.
   always @(negedge Clock) begin
      logic [7:0] e;
      if (resetB) begin
         stallB = 0;
      end else begin
         if (stallB) begin
            checkOutput("holdValidB", readValidB, 1);
            if (readValidB) checkOutput("holdDataB", readDataB, heldB);
         end
         if (readValidB && readReady) begin
            if (expB.size() == 0) begin
               checkOutput("unexpectedWordB", readDataB, 32'hFFFF_FFFF);
            end else begin
               e = expB.pop_front();
               checkOutput("readDataB", readDataB, e);
            end
            stallB = 0;
         end else if (readValidB) begin
            stallB = 1;
            heldB  = readDataB;
         end else begin
            stallB = 0;
         end
      end
   end

   initial begin
      $display("[TB] start");

      // Reset values.
      doReset(0);
      checkOutput("rstReadValid", readValidA, 0);
      checkOutput("rstReadData", readDataA, 0);
      checkOutput("rstRecordDone", recordDoneA, 0);
      checkOutput("rstTriggerAddr", triggerAddrA, 0);
      checkOutput("rstSampleCount", sampleCountA, 0);

      // EnableRecording while idle has no effect.
      enableRecording = 1'b1;
      tick();
      tick();
      checkOutput("idleIgnoreDone", recordDoneA, 0);
      enableRecording = 1'b0;

      // Basic capture: 20 pre-trigger, 5 post-trigger.
      armed = 1'b1;
      tick();
      for (int i = 1; i <= 20; i++) applyStimulus(1'b1, 8'(i), 1'b1, 0);
      enableRecording = 1'b1;
      postTrigA = 11'd5;
      for (int i = 21; i <= 25; i++) applyStimulus(1'b1, 8'(i), 1'b1, 0);
      checkOutput("t1RecordDone", recordDoneA, 1);
      checkOutput("t1SampleCount", sampleCountA, 25);
      checkOutput("t1TriggerAddr", triggerAddrA, 20);
      readReady = 1'b1;
      waitDrain(0, 200, 1'b0);
      tick(); tick(); tick();
      checkOutput("t1ValidLow", readValidA, 0);
      checkOutput("t1DoneHeld", recordDoneA, 1);

      // Zero-length post-trigger on the first armed cycle.
      doReset(0);
      armed = 1'b1;
      tick();
      enableRecording = 1'b1;
      postTrigA = 11'd0;
      applyStimulus(1'b1, 8'hAA, 1'b0, 0);
      checkOutput("t3RecordDone", recordDoneA, 1);
      checkOutput("t3SampleCount", sampleCountA, 0);
      readReady = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      checkOutput("t3ValidLow", readValidA, 0);

      // Saturated post-trigger length with random backpressure.
      doReset(0);
      armed = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hF0 + i), 1'b0, 0);
      enableRecording = 1'b1;
      postTrigA = 11'd2000;
      for (int i = 0; i < 1024; i++) applyStimulus(1'b1, 8'(i + (i >> 8)), 1'b1, 0);
      checkOutput("t4RecordDone", recordDoneA, 1);
      checkOutput("t4SampleCount", sampleCountA, 1024);
      checkOutput("t4TriggerAddr", triggerAddrA, 5);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hEE, 1'b0, 0);
      waitDrain(0, 6000, 1'b1);
      tick(); tick(); tick();
      checkOutput("t4ValidLow", readValidA, 0);

      // Reset mid-readout after three words, then capture again.
      doReset(0);
      armed = 1'b1;
      readReady = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b1, 0);
      enableRecording = 1'b1;
      postTrigA = 11'd3;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b1, 0);
      for (int n = 0; n < 100 && expA.size() > 4; n++) tick();
      checkOutput("t6ThreeWords", expA.size(), 4);
      resetA = 1'b1;
      readReady = 1'b0;
      enableRecording = 1'b0;
      tick();
      checkOutput("t6ValidLow", readValidA, 0);
      checkOutput("t6ReadData", readDataA, 0);
      checkOutput("t6RecordDone", recordDoneA, 0);
      checkOutput("t6SampleCount", sampleCountA, 0);
      checkOutput("t6TriggerAddr", triggerAddrA, 0);
      resetA = 1'b0;
      expA.delete();
      readReady = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h70 + i), 1'b1, 0);
      enableRecording = 1'b1;
      postTrigA = 11'd2;
      for (int i = 3; i < 5; i++) applyStimulus(1'b1, 8'(8'h70 + i), 1'b1, 0);
      checkOutput("t6bSampleCount", sampleCountA, 5);
      checkOutput("t6bTriggerAddr", triggerAddrA, 3);
      waitDrain(0, 200, 1'b0);

      // 16-word buffer: wrap-around and history saturation.
      resetA = 1'b1;
      doReset(1);
      armed = 1'b1;
      tick();
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'(i), (i >= 28), 1);
      enableRecording = 1'b1;
      postTrigB = 5'd4;
      for (int i = 40; i < 44; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1);
      checkOutput("t2RecordDone", recordDoneB, 1);
      checkOutput("t2SampleCount", sampleCountB, 16);
      checkOutput("t2TriggerAddr", triggerAddrB, 8);
      readReady = 1'b1;
      waitDrain(1, 200, 1'b0);
      tick(); tick(); tick();
      checkOutput("t2ValidLow", readValidB, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checkCount, failCount);
      $finish;
   end

endmodule
